// File: rtl/muxn_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module : muxn_pipe_pkg
// Desc   : Shared word-width default and skid-buffer state encoding for the
//          muxn_pipe select pipeline.
// Rev    : 1.0  initial release
// ============================================================================
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

package muxn_pipe_pkg;

    localparam int MUXN_WORD_WIDTH = `WORD_WIDTH;

    typedef enum logic [1:0] {
        MUXN_EMPTY = 2'd0,
        MUXN_ONE   = 2'd1,
        MUXN_TWO   = 2'd2
    } muxn_state_e;

endpackage

`default_nettype wire

// File: rtl/muxn_pipe_if.sv
`default_nettype none
// ============================================================================
// Module : muxn_pipe_if
// Desc   : Upstream/downstream handshake bundle of muxn_pipe. The master side
//          drives the request and consumes the result; the slave is the block.
// Rev    : 1.0  initial release
// ============================================================================
interface muxn_pipe_if
    import muxn_pipe_pkg::*;
#(
    parameter int WORD_WIDTH = MUXN_WORD_WIDTH,
    parameter int NUM_INPUTS = 4,
    parameter int SEL_WIDTH  = 2
);

    logic [NUM_INPUTS*WORD_WIDTH-1:0] in_data;
    logic [SEL_WIDTH-1:0]             in_sel;
    logic                             in_valid;
    logic                             in_ready;
    logic                             flush;
    logic [WORD_WIDTH-1:0]            out_data;
    logic [SEL_WIDTH-1:0]             out_sel;
    logic                             out_valid;
    logic                             out_ready;
    logic                             sel_err;

    modport master (
        output in_data, in_sel, in_valid, flush, out_ready,
        input  in_ready, out_data, out_sel, out_valid, sel_err
    );

    modport slave (
        input  in_data, in_sel, in_valid, flush, out_ready,
        output in_ready, out_data, out_sel, out_valid, sel_err
    );

endinterface

`default_nettype wire

// File: rtl/muxn_pipe_sel.sv
`default_nettype none
// ============================================================================
// Module : muxn_sel
// Desc   : Combinational N-way word select; an out-of-range select falls back
//          to input 0 and reports an effective select of 0.
// Rev    : 1.0  initial release
// ============================================================================
module muxn_sel
    import muxn_pipe_pkg::*;
#(
    parameter int WORD_WIDTH = MUXN_WORD_WIDTH,
    parameter int NUM_INPUTS = 4,
    parameter int SEL_WIDTH  = 2
) (
    input  wire logic [NUM_INPUTS*WORD_WIDTH-1:0] i_data,
    input  wire logic [SEL_WIDTH-1:0]             i_sel,
    output logic      [WORD_WIDTH-1:0]            o_word,
    output logic      [SEL_WIDTH-1:0]             o_sel
);

    always_comb begin
        o_word = i_data[0 +: WORD_WIDTH];
        o_sel  = '0;
        for (int i = 1; i < NUM_INPUTS; i++) begin
            if (i_sel == SEL_WIDTH'(i)) begin
                o_word = i_data[i*WORD_WIDTH +: WORD_WIDTH];
                o_sel  = SEL_WIDTH'(i);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/muxn_pipe.sv
`default_nettype none
// ============================================================================
// Module : muxn_pipe
// Desc   : Pipelined N-way word select behind a two-entry skid buffer with a
//          registered in_ready and synchronous flush. Optional sticky select
//          range checker enabled by MUXN_PIPE_SEL_CHECK_EN.
// Rev    : 1.0  initial release
// ============================================================================
module muxn_pipe
    import muxn_pipe_pkg::*;
#(
    parameter int WORD_WIDTH = MUXN_WORD_WIDTH,
    parameter int NUM_INPUTS = 4,
    parameter int SEL_WIDTH  = 2
) (
    input  wire logic  clk,
    input  wire logic  rst_n,
    muxn_pipe_if.slave bus
);

    logic [WORD_WIDTH-1:0] w_cap_word;
    logic [SEL_WIDTH-1:0]  w_cap_sel;
    logic                  w_accept;

    muxn_state_e           state_q, state_d;
    logic [WORD_WIDTH-1:0] main_data_q, main_data_d;
    logic [SEL_WIDTH-1:0]  main_sel_q, main_sel_d;
    logic [WORD_WIDTH-1:0] skid_data_q, skid_data_d;
    logic [SEL_WIDTH-1:0]  skid_sel_q, skid_sel_d;
    logic                  in_ready_q, in_ready_d;

    muxn_sel #(
        .WORD_WIDTH (WORD_WIDTH),
        .NUM_INPUTS (NUM_INPUTS),
        .SEL_WIDTH  (SEL_WIDTH)
    ) u_sel (
        .i_data (bus.in_data),
        .i_sel  (bus.in_sel),
        .o_word (w_cap_word),
        .o_sel  (w_cap_sel)
    );

    // A transfer offered during flush is dropped, never captured.
    assign w_accept = bus.in_valid && in_ready_q && !bus.flush;

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_sel_d  = main_sel_q;
        skid_data_d = skid_data_q;
        skid_sel_d  = skid_sel_q;
        case (state_q)
            MUXN_EMPTY: begin
                if (w_accept) begin
                    main_data_d = w_cap_word;
                    main_sel_d  = w_cap_sel;
                    state_d     = MUXN_ONE;
                end
            end
            MUXN_ONE: begin
                if (w_accept && bus.out_ready) begin
                    main_data_d = w_cap_word;
                    main_sel_d  = w_cap_sel;
                end else if (w_accept) begin
                    skid_data_d = w_cap_word;
                    skid_sel_d  = w_cap_sel;
                    state_d     = MUXN_TWO;
                end else if (bus.out_ready) begin
                    state_d     = MUXN_EMPTY;
                end
            end
            MUXN_TWO: begin
                if (bus.out_ready) begin
                    main_data_d = skid_data_q;
                    main_sel_d  = skid_sel_q;
                    state_d     = MUXN_ONE;
                end
            end
            default: state_d = MUXN_EMPTY;
        endcase
        if (bus.flush) begin
            state_d = MUXN_EMPTY;
        end
        // Ready is a function of the next state so it can be registered.
        in_ready_d = (state_d != MUXN_TWO);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= MUXN_EMPTY;
            main_data_q <= '0;
            main_sel_q  <= '0;
            skid_data_q <= '0;
            skid_sel_q  <= '0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_sel_q  <= main_sel_d;
            skid_data_q <= skid_data_d;
            skid_sel_q  <= skid_sel_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = (state_q != MUXN_EMPTY);
    assign bus.out_data  = main_data_q;
    assign bus.out_sel   = main_sel_q;

`ifdef MUXN_PIPE_SEL_CHECK_EN
    logic w_sel_oor;
    logic sel_err_q, sel_err_d;

    assign w_sel_oor = ({1'b0, bus.in_sel} >= (SEL_WIDTH+1)'(NUM_INPUTS));

    always_comb begin
        sel_err_d = sel_err_q | (w_accept & w_sel_oor);
    end

    // Sticky until reset; flush intentionally leaves it alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_err_q <= 1'b0;
        end else begin
            sel_err_q <= sel_err_d;
`ifndef SYNTHESIS
            if (w_accept && w_sel_oor) begin
                $error("muxn_pipe: out-of-range select %0d accepted", bus.in_sel);
            end
`endif
        end
    end

    assign bus.sel_err = sel_err_q;
`else
    assign bus.sel_err = 1'b0;
`endif

endmodule

`default_nettype wire
